// File: rtl/alu_serial_seq.sv
// ============================================================================
// Module   : alu_serial_seq
// Purpose  : Bit-serial operand sequencer wrapped around the 1-bit alu stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_serial_seq #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             a0,
  output logic             x0,
  output logic             x1,
  output logic             f,
  output logic             o0,
  output logic             no0,
  output logic             o1,
  output logic             no1,
  input  logic             alu_out,
  input  logic             alu_ncout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_x;
  logic             r_f;
  logic [CW-1:0]    r_count;
  logic [1:0]       r_op;
  logic             r_done;
  logic             w_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_x     <= '0;
      r_f     <= 1'b0;
      r_count <= '0;
      r_op    <= 2'b00;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= op;
            r_x     <= operand;
            r_count <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // A shifts out its LSB to the alu while the new result bit enters at the MSB.
          r_a     <= {alu_out, r_a[WIDTH-1:1]};
          r_x     <= {r_x[0], r_x[WIDTH-1:1]};
          r_f     <= ~alu_ncout;
          r_count <= r_count + 1'b1;
          if (r_count == C_LAST) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_run = (r_state == RUN);

  assign busy  = w_run;
  assign done  = r_done;
  assign acc   = r_a;
  assign carry = r_f;

  assign a0 = r_a[0];
  assign x0 = r_x[0];
  assign x1 = r_x[1];
  assign f  = r_f;

  // Rails are all low outside RUN so the alu selector is inert while idle.
  assign o1  = w_run &  r_op[1];
  assign no1 = w_run & ~r_op[1];
  assign o0  = w_run &  r_op[0];
  assign no0 = w_run & ~r_op[0];

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_seq.sv
// ============================================================================
// Module   : tb_alu_serial_seq
// Purpose  : Directed vector bench for alu_serial_seq with a 1-bit alu model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_serial_seq;

  localparam int WIDTH = 12;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic             busy, done, carry;
  logic [WIDTH-1:0] acc;
  logic             a0, x0, x1, f;
  logic             o0, no0, o1, no1;
  logic             alu_out, alu_ncout;

  int vectors;
  int miscompares;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand   (operand),
    .busy      (busy),
    .done      (done),
    .acc       (acc),
    .carry     (carry),
    .a0        (a0),
    .x0        (x0),
    .x1        (x1),
    .f         (f),
    .o0        (o0),
    .no0       (no0),
    .o1        (o1),
    .no1       (no1),
    .alu_out   (alu_out),
    .alu_ncout (alu_ncout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational 1-bit alu stage, selected by the opcode rails.
  always_comb begin
    alu_out   = 1'b0;
    alu_ncout = ~f;
    if (o1 | no1) begin
      case ({o1, o0})
        2'b00: begin alu_out = x0;           alu_ncout = ~(f & ~a0); end
        2'b01: begin alu_out = ~(a0 | x0);   alu_ncout = ~f;         end
        2'b10: begin alu_out = a0 ^ x0 ^ f;  alu_ncout = ~((a0 & x0) | (a0 & f) | (x0 & f)); end
        default: begin alu_out = x1;         alu_ncout = ~f;         end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    int               pulse_at;
    logic [WIDTH-1:0] exp_acc;
    logic             exp_carry;
  } vec_t;

  vec_t tbl [11];

  logic [WIDTH-1:0] cap_acc;
  logic             cap_carry;
  int               busy_cnt;
  int               done_cnt;

  // Launch one operation and measure busy/done; optionally pulse start mid-run.
  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] d, input int pulse_at);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; operand = d;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0; n = 0;
    while (busy && n < 100) begin
      busy_cnt++;
      if (busy_cnt == pulse_at) begin
        start = 1'b1; op = 2'b10; operand = 12'hFFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    cap_acc = acc; cap_carry = carry;
    while (done && n < 100) begin
      done_cnt++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    start = 1'b0; op = 2'b00; operand = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_acc",   32'(acc),   32'h0);
    check("reset_carry", 32'(carry), 32'h0);
    check("reset_busy",  32'(busy),  32'h0);
    check("reset_done",  32'(done),  32'h0);
    check("reset_rails", 32'({o0, no0, o1, no1}), 32'h0);
    rst_n = 1'b1;

    tbl[0]  = '{2'b00, 12'h123, -1, 12'h123, 1'b0};
    tbl[1]  = '{2'b00, 12'h0A5, -1, 12'h0A5, 1'b0};
    tbl[2]  = '{2'b00, 12'h005, -1, 12'h005, 1'b0};
    tbl[3]  = '{2'b10, 12'h003, -1, 12'h008, 1'b0};
    tbl[4]  = '{2'b10, 12'hFFF, -1, 12'h007, 1'b1};
    tbl[5]  = '{2'b11, 12'hFFF, -1, 12'hFFF, 1'b1};
    tbl[6]  = '{2'b10, 12'h000, -1, 12'h000, 1'b1};
    tbl[7]  = '{2'b11, 12'h006, -1, 12'h003, 1'b1};
    tbl[8]  = '{2'b11, 12'h001, -1, 12'h800, 1'b1};
    tbl[9]  = '{2'b00, 12'h0F0, -1, 12'h0F0, 1'b0};
    tbl[10] = '{2'b01, 12'h00F,  3, 12'hF00, 1'b0};

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].op, tbl[i].operand, tbl[i].pulse_at);
      check($sformatf("v%0d_acc", i),   32'(cap_acc),   32'(tbl[i].exp_acc));
      check($sformatf("v%0d_carry", i), 32'(cap_carry), 32'(tbl[i].exp_carry));
      check($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), 32'd12);
      check($sformatf("v%0d_done_cycles", i), 32'(done_cnt), 32'd1);
    end

    // Start held through the done cycle launches a second op on that edge.
    begin
      int n;
      @(negedge clk);
      start = 1'b1; op = 2'b10; operand = 12'h0FF;
      @(negedge clk);
      check("b2b_first_busy", 32'(busy), 32'h1);
      check("b2b_rails_add", 32'({o1, no1, o0, no0}), 32'b1001);
      op = 2'b11; operand = 12'h002;
      n = 0;
      while (!done && n < 100) begin @(negedge clk); n++; end
      check("b2b_first_done", 32'(done), 32'h1);
      check("b2b_first_acc",  32'(acc),  32'hFFF);
      @(negedge clk);
      check("b2b_second_busy", 32'(busy), 32'h1);
      check("b2b_rails_ror", 32'({o1, no1, o0, no0}), 32'b1010);
      start = 1'b0;
      n = 0;
      while (!done && n < 100) begin @(negedge clk); n++; end
      check("b2b_second_done", 32'(done), 32'h1);
      check("b2b_second_acc",  32'(acc),  32'h001);
      check("b2b_second_carry", 32'(carry), 32'h0);
    end

    // Reset asserted part-way through an ADD aborts it with no done pulse.
    begin
      int seen;
      @(negedge clk);
      start = 1'b1; op = 2'b10; operand = 12'h555;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_busy_before", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check("abort_acc",   32'(acc),   32'h0);
      check("abort_carry", 32'(carry), 32'h0);
      check("abort_busy",  32'(busy),  32'h0);
      check("abort_rails", 32'({o0, no0, o1, no1}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("abort_no_done", 32'(seen), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
